// File: rtl/rob_commit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rob_commit_if                                                   |
// | Purpose  : Issue/writeback/commit/redirect bundle for the rob_commit stage.|
// |            Optional stats outputs exist under ROB_COMMIT_STATS_EN.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface rob_commit_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    localparam int ID_W = $clog2(DEPTH);

    logic              alloc_en_i;
    logic [REG_W-1:0]  alloc_regaddr_i;
    logic [1:0]        alloc_branch_tag_i;
    logic [DATA_W-1:0] alloc_pc_i;
    logic [ID_W-1:0]   alloc_id_o;
    logic              alloc_full_o;

    logic              wb_en_i;
    logic [ID_W-1:0]   wb_id_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              wb_cond_i;

    logic              we_regfile_o;
    logic [REG_W-1:0]  waddr_regfile_o;
    logic [ID_W-1:0]   wid_regfile_o;
    logic [DATA_W-1:0] wdata_regfile_o;
    logic              rdy_o;
    logic              rst_c;
    logic              en_if_o;
    logic [DATA_W-1:0] pc_if_o;
    logic              empty_o;
    logic [ID_W:0]     count_o;
`ifdef ROB_COMMIT_STATS_EN
    logic [31:0]       commit_cnt_o;
    logic [31:0]       flush_cnt_o;
`endif

    modport master (
`ifdef ROB_COMMIT_STATS_EN
        input  commit_cnt_o, flush_cnt_o,
`endif
        output alloc_en_i, alloc_regaddr_i, alloc_branch_tag_i, alloc_pc_i,
        output wb_en_i, wb_id_i, wb_data_i, wb_cond_i,
        input  alloc_id_o, alloc_full_o,
        input  we_regfile_o, waddr_regfile_o, wid_regfile_o, wdata_regfile_o,
        input  rdy_o, rst_c, en_if_o, pc_if_o, empty_o, count_o
    );

    modport slave (
`ifdef ROB_COMMIT_STATS_EN
        output commit_cnt_o, flush_cnt_o,
`endif
        input  alloc_en_i, alloc_regaddr_i, alloc_branch_tag_i, alloc_pc_i,
        input  wb_en_i, wb_id_i, wb_data_i, wb_cond_i,
        output alloc_id_o, alloc_full_o,
        output we_regfile_o, waddr_regfile_o, wid_regfile_o, wdata_regfile_o,
        output rdy_o, rst_c, en_if_o, pc_if_o, empty_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rob_commit                                                      |
// | Purpose  : Circular reorder buffer with in-order single-entry commit and   |
// |            mispredict flush/redirect. Macro ROB_COMMIT_STATS_EN adds       |
// |            commit/flush event counters.                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rob_commit #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic        clk,
    input  logic        rst,
    rob_commit_if.slave bus
);
    localparam int            ID_W         = $clog2(DEPTH);
    localparam logic [ID_W:0] c_depth      = (ID_W+1)'(DEPTH);
    localparam logic [ID_W-1:0] c_id_one   = ID_W'(1);
    localparam logic [1:0]    c_tag_taken  = 2'b01;
    localparam logic [1:0]    c_tag_ntaken = 2'b10;

    // Entry state
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_cond;
    logic [REG_W-1:0]  r_regaddr [DEPTH];
    logic [1:0]        r_tag     [DEPTH];
    logic [DATA_W-1:0] r_pc      [DEPTH];
    logic [DATA_W-1:0] r_data    [DEPTH];

    logic [ID_W-1:0]   r_head;
    logic [ID_W-1:0]   r_tail;
    logic [ID_W:0]     r_count;
    logic              r_full;
    logic              r_empty;

    // Registered commit/redirect outputs
    logic              r_rdy;
    logic              r_we;
    logic [REG_W-1:0]  r_waddr;
    logic [ID_W-1:0]   r_wid;
    logic [DATA_W-1:0] r_wdata;
    logic              r_flush;
    logic              r_en_if;
    logic [DATA_W-1:0] r_pc_if;

    logic              w_alloc;
    logic              w_wb;
    logic              w_commit;
    logic              w_mispredict;
    logic [ID_W:0]     w_count_nxt;

    // The flush cycle (r_flush high) freezes all alloc, writeback and commit.
    assign w_alloc  = bus.alloc_en_i && !r_full && !r_flush;
    assign w_wb     = bus.wb_en_i && !r_flush &&
                      r_valid[bus.wb_id_i] && !r_done[bus.wb_id_i];
    assign w_commit = !r_flush && r_valid[r_head] && r_done[r_head];

    assign w_mispredict = w_commit &&
        ((r_tag[r_head] == c_tag_taken  && !r_cond[r_head]) ||
         (r_tag[r_head] == c_tag_ntaken &&  r_cond[r_head]));

    always_comb begin
        w_count_nxt = r_count;
        if (w_mispredict) begin
            w_count_nxt = '0;
        end else if (w_alloc && !w_commit) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_alloc && w_commit) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Pointers, occupancy and per-entry valid/done bits. Alloc never targets
    // the committing slot because alloc is blocked while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_valid <= '0;
                r_done  <= '0;
            end else begin
                if (w_alloc) begin
                    r_valid[r_tail] <= 1'b1;
                    r_done[r_tail]  <= 1'b0;
                    r_tail          <= r_tail + c_id_one;
                end
                if (w_wb) begin
                    r_done[bus.wb_id_i] <= 1'b1;
                end
                if (w_commit) begin
                    r_valid[r_head] <= 1'b0;
                    r_done[r_head]  <= 1'b0;
                    r_head          <= r_head + c_id_one;
                end
            end
        end
    end

    // Payload storage is qualified by the valid/done bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_regaddr[r_tail] <= bus.alloc_regaddr_i;
            r_tag[r_tail]     <= bus.alloc_branch_tag_i;
            r_pc[r_tail]      <= bus.alloc_pc_i;
        end
        if (w_wb) begin
            r_data[bus.wb_id_i] <= bus.wb_data_i;
            r_cond[bus.wb_id_i] <= bus.wb_cond_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy   <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wid   <= '0;
            r_wdata <= '0;
            r_flush <= 1'b0;
            r_en_if <= 1'b0;
            r_pc_if <= '0;
        end else begin
            r_rdy   <= w_commit;
            r_we    <= w_commit && (r_regaddr[r_head] != '0);
            r_waddr <= w_commit ? r_regaddr[r_head] : '0;
            r_wid   <= w_commit ? r_head : '0;
            r_wdata <= w_commit ? r_data[r_head] : '0;
            r_flush <= w_mispredict;
            r_en_if <= w_mispredict;
            r_pc_if <= w_mispredict ? r_pc[r_head] : '0;
        end
    end

`ifdef ROB_COMMIT_STATS_EN
    logic [31:0] r_commit_cnt;
    logic [31:0] r_flush_cnt;

    // Counters advance on the edge that raises the matching output pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_commit) begin
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end
            if (w_mispredict) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.commit_cnt_o = r_commit_cnt;
    assign bus.flush_cnt_o  = r_flush_cnt;
`endif

    assign bus.alloc_id_o      = r_tail;
    assign bus.alloc_full_o    = r_full;
    assign bus.empty_o         = r_empty;
    assign bus.count_o         = r_count;
    assign bus.rdy_o           = r_rdy;
    assign bus.we_regfile_o    = r_we;
    assign bus.waddr_regfile_o = r_waddr;
    assign bus.wid_regfile_o   = r_wid;
    assign bus.wdata_regfile_o = r_wdata;
    assign bus.rst_c           = r_flush;
    assign bus.en_if_o         = r_en_if;
    assign bus.pc_if_o         = r_pc_if;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rob_commit                                                   |
// | Purpose  : Queue-model bench for rob_commit (DEPTH=4): directed scenarios  |
// |            with literal expectations followed by a randomized run.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_rob_commit;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ID_W   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_commit_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    rob_commit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the ROB as a program-ordered queue of in-flight entries.
    typedef struct {
        int                id;
        logic [REG_W-1:0]  ra;
        logic [1:0]        tag;
        logic [DATA_W-1:0] pc;
        bit                done;
        logic [DATA_W-1:0] data;
        bit                cond;
    } ent_t;

    ent_t              rob_q[$];
    int                next_id    = 0;
    bit                model_live = 1'b0;
    bit                e_rdy, e_we, e_flush;
    int                e_wid;
    logic [REG_W-1:0]  e_waddr;
    logic [DATA_W-1:0] e_wdata, e_pc;
    logic [31:0]       e_commits, e_flushes;

    always @(posedge clk) begin : model
        bit   flushing, was_full, fire, mis;
        ent_t h;
        ent_t n;
        flushing = e_flush;
        mis      = 1'b0;
        e_rdy = 0; e_we = 0; e_flush = 0; e_wid = 0;
        e_waddr = '0; e_wdata = '0; e_pc = '0;
        if (rst) begin
            rob_q.delete();
            next_id    = 0;
            model_live = 1'b1;
            e_commits  = '0;
            e_flushes  = '0;
        end else if (model_live && !flushing) begin
            was_full = (rob_q.size() == DEPTH);
            fire     = (rob_q.size() > 0) && rob_q[0].done;
            if (bus.wb_en_i) begin
                foreach (rob_q[k]) begin
                    if (rob_q[k].id == int'(bus.wb_id_i) && !rob_q[k].done) begin
                        rob_q[k].done = 1'b1;
                        rob_q[k].data = bus.wb_data_i;
                        rob_q[k].cond = bus.wb_cond_i;
                    end
                end
            end
            if (fire) begin
                h       = rob_q.pop_front();
                mis     = (h.tag == 2'b01 && !h.cond) || (h.tag == 2'b10 && h.cond);
                e_rdy   = 1'b1;
                e_wid   = h.id;
                e_waddr = h.ra;
                e_wdata = h.data;
                e_we    = (h.ra != 0);
                e_commits++;
                if (mis) begin
                    e_flush = 1'b1;
                    e_pc    = h.pc;
                    rob_q.delete();
                    next_id = 0;
                    e_flushes++;
                end
            end
            if (!mis && bus.alloc_en_i && !was_full) begin
                n.id   = next_id;
                n.ra   = bus.alloc_regaddr_i;
                n.tag  = bus.alloc_branch_tag_i;
                n.pc   = bus.alloc_pc_i;
                n.done = 1'b0;
                n.data = '0;
                n.cond = 1'b0;
                rob_q.push_back(n);
                next_id = (next_id + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("m_rdy",   bus.rdy_o,           e_rdy);
            chk("m_we",    bus.we_regfile_o,    e_we);
            chk("m_waddr", bus.waddr_regfile_o, e_waddr);
            chk("m_wid",   bus.wid_regfile_o,   e_wid);
            chk("m_wdata", bus.wdata_regfile_o, e_wdata);
            chk("m_rst_c", bus.rst_c,           e_flush);
            chk("m_en_if", bus.en_if_o,         e_flush);
            chk("m_pc_if", bus.pc_if_o,         e_pc);
            chk("m_empty", bus.empty_o,         rob_q.size() == 0);
            chk("m_full",  bus.alloc_full_o,    rob_q.size() == DEPTH);
            chk("m_count", bus.count_o,         rob_q.size());
            chk("m_id",    bus.alloc_id_o,      next_id);
`ifdef ROB_COMMIT_STATS_EN
            chk("m_ccnt",  bus.commit_cnt_o,    e_commits);
            chk("m_fcnt",  bus.flush_cnt_o,     e_flushes);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.alloc_en_i = 0; bus.alloc_regaddr_i = '0; bus.alloc_branch_tag_i = '0; bus.alloc_pc_i = '0;
        bus.wb_en_i = 0; bus.wb_id_i = '0; bus.wb_data_i = '0; bus.wb_cond_i = 0;
    endtask

    task automatic alloc(input int ra, input int tag, input logic [DATA_W-1:0] pc);
        bus.alloc_en_i = 1; bus.alloc_regaddr_i = REG_W'(ra);
        bus.alloc_branch_tag_i = 2'(tag); bus.alloc_pc_i = pc;
        step();
        bus.alloc_en_i = 0;
    endtask

    task automatic wb(input int id, input logic [DATA_W-1:0] data, input bit cond);
        bus.wb_en_i = 1; bus.wb_id_i = ID_W'(id); bus.wb_data_i = data; bus.wb_cond_i = cond;
        step();
        bus.wb_en_i = 0;
    endtask

    initial begin
        int h;
        clear_inputs();
        rst = 1;
        step(); step();
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_count", bus.count_o, 0);
        chk("rst_rdy",   bus.rdy_o,   0);
        chk("rst_id",    bus.alloc_id_o, 0);
        rst = 0;

        // fill to full, then an ignored fifth alloc
        for (int i = 0; i < 4; i++) begin
            chk("fill_id", bus.alloc_id_o, i);
            alloc(i + 1, 0, 0);
        end
        chk("full_flag", bus.alloc_full_o, 1);
        chk("full_count", bus.count_o, 4);
        alloc(5, 0, 0);
        chk("full_ignored", bus.count_o, 4);

        // out-of-order writeback, in-order commit
        wb(2, 32'h30, 0);
        wb(1, 32'h20, 0);
        wb(0, 32'h10, 0);
        step();
        chk("c0_rdy", bus.rdy_o, 1); chk("c0_wid", bus.wid_regfile_o, 0);
        chk("c0_data", bus.wdata_regfile_o, 32'h10); chk("c0_addr", bus.waddr_regfile_o, 1);
        step();
        chk("c1_wid", bus.wid_regfile_o, 1); chk("c1_data", bus.wdata_regfile_o, 32'h20);
        step();
        chk("c2_wid", bus.wid_regfile_o, 2); chk("c2_data", bus.wdata_regfile_o, 32'h30);
        step();
        chk("id3_held", bus.rdy_o, 0); chk("id3_count", bus.count_o, 1);
        wb(3, 32'h40, 0);
        step();
        chk("c3_wid", bus.wid_regfile_o, 3); chk("c3_empty", bus.empty_o, 1);

        // predicted not-taken resolves taken: flush and redirect
        alloc(7, 2'b10, 32'h1000);
        alloc(8, 0, 0);
        wb(1, 32'h55, 0);
        wb(0, 32'h66, 1);
        step();
        chk("mp_rst_c", bus.rst_c, 1); chk("mp_en_if", bus.en_if_o, 1);
        chk("mp_pc", bus.pc_if_o, 32'h1000); chk("mp_wdata", bus.wdata_regfile_o, 32'h66);
        alloc(9, 0, 0);
        chk("mp_empty", bus.empty_o, 1); chk("mp_drop", bus.rst_c, 0);
        chk("mp_noalloc", bus.count_o, 0); chk("mp_id0", bus.alloc_id_o, 0);
        step();
        chk("mp_young", bus.rdy_o, 0);

        // predicted taken resolves taken; then a write to r0
        alloc(3, 2'b01, 32'h2000);
        wb(0, 32'h77, 1);
        step();
        chk("pt_rdy", bus.rdy_o, 1); chk("pt_nofl", bus.rst_c, 0);
        alloc(0, 0, 0);
        wb(1, 32'h88, 0);
        step();
        chk("r0_rdy", bus.rdy_o, 1); chk("r0_we", bus.we_regfile_o, 0); chk("r0_wid", bus.wid_regfile_o, 1);

        // commit and alloc on the same edge, across pointer wrap
        h = 2;
        chk("wr_id", bus.alloc_id_o, 2);
        alloc(10, 0, 0);
        for (int r = 0; r < 10; r++) begin
            wb(h, 32'(r + 1), 0);
            chk("wr_tail", bus.alloc_id_o, (h + 1) % 4);
            alloc(11 + r, 0, 0);
            chk("wr_wid", bus.wid_regfile_o, h);
            chk("wr_count", bus.count_o, 1);
            h = (h + 1) % 4;
        end
        wb(h, 32'h0, 0);
        step();

        // reset with entries in flight
        alloc(1, 0, 0); alloc(2, 0, 0); alloc(3, 0, 0);
        chk("rr_count", bus.count_o, 3);
        bus.wb_en_i = 1; bus.wb_id_i = ID_W'(bus.alloc_id_o - 2'd3); bus.wb_data_i = 32'h5; bus.wb_cond_i = 0;
        step();
        bus.wb_en_i = 0;
        rst = 1;
        step();
        rst = 0;
        chk("rr_rdy", bus.rdy_o, 0); chk("rr_empty", bus.empty_o, 1);
        chk("rr_cnt0", bus.count_o, 0); chk("rr_id0", bus.alloc_id_o, 0);
        alloc(4, 0, 0);
        chk("rr_alloc", bus.count_o, 1);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst                    = ($urandom_range(0, 99) == 0);
            bus.alloc_en_i         = ($urandom_range(0, 9) < 6);
            bus.alloc_regaddr_i    = REG_W'($urandom_range(0, 31));
            bus.alloc_branch_tag_i = 2'($urandom_range(0, 3));
            bus.alloc_pc_i         = $urandom;
            bus.wb_en_i            = ($urandom_range(0, 9) < 6);
            bus.wb_id_i            = ID_W'($urandom_range(0, 3));
            bus.wb_data_i          = $urandom;
            bus.wb_cond_i          = 1'($urandom_range(0, 1));
            step();
        end
        rst = 0;
        clear_inputs();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
